// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial bit-pattern detector with registered match pulse and saturating match counter
module seq_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             X,
   input  logic             clr_cnt,
   output logic             Y,
   output logic [CNT_W-1:0] match_cnt,
   output logic [4:0]       state_dbg
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Bit i of the pattern in arrival order (i = 0 is the first bit received).
   function automatic int pat_bit(input int i);
      logic [15:0] p;
      p = 16'(PATTERN) >> (PAT_LEN - 1 - i);
      return p[0] ? 1 : 0;
   endfunction

   // Longest prefix length that ends the stream "prefix(s) followed by x".
   // This is the result of walking the failure chain from s, evaluated
   // directly; a return of PAT_LEN means the whole pattern just completed.
   function automatic int calc_ext(input int s, input int x);
      int res;
      int c;
      bit ok;
      res = 0;
      for (int k = 1; k <= s + 1; k++) begin
         ok = 1'b1;
         for (int j = 0; j < k; j++) begin
            c = (s + 1 - k + j == s) ? x : pat_bit(s + 1 - k + j);
            if (c != pat_bit(j)) ok = 1'b0;
         end
         if (ok) res = k;
      end
      return res;
   endfunction

   // Failure value of the full pattern: longest proper prefix that is also a suffix.
   function automatic int calc_border();
      int res;
      bit ok;
      res = 0;
      for (int k = 1; k < PAT_LEN; k++) begin
         ok = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (pat_bit(PAT_LEN - k + j) != pat_bit(j)) ok = 1'b0;
         end
         if (ok) res = k;
      end
      return res;
   endfunction

   localparam int BORDER   = calc_border();
   localparam int RESTART  = OVERLAP ? BORDER : 0;

   logic [4:0]           state     = '0;
   logic                 y_q       = 1'b0;
   logic [CNT_W-1:0]     cnt_q     = '0;

   // col[b][s] is bit b of {hit, next_state} contributed by row s; only the
   // row equal to the current state contributes, so an OR merges the rows.
   logic [5:0][PAT_LEN-1:0] col;
   logic [5:0]              sel;
   logic [4:0]              nxt_state;
   logic                    nxt_hit;

   for (genvar s = 0; s < PAT_LEN; s++) begin : g_row
      localparam int K0 = calc_ext(s, 0);
      localparam int K1 = calc_ext(s, 1);
      localparam logic [5:0] T0 = (K0 == PAT_LEN) ? {1'b1, 5'(RESTART)} : {1'b0, 5'(K0)};
      localparam logic [5:0] T1 = (K1 == PAT_LEN) ? {1'b1, 5'(RESTART)} : {1'b0, 5'(K1)};
      logic [5:0] contrib;
      assign contrib = (state == 5'(s)) ? (X ? T1 : T0) : 6'd0;
      for (genvar b = 0; b < 6; b++) begin : g_bit
         assign col[b][s] = contrib[b];
      end
   end

   for (genvar b = 0; b < 6; b++) begin : g_sel
      assign sel[b] = |col[b];
   end

   assign nxt_state = sel[4:0];
   assign nxt_hit   = sel[5];

   // Detector state, match pulse and counter; reset overrides everything and
   // a counter clear beats a coincident match.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= '0;
         y_q   <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (en) begin
            state <= nxt_state;
            y_q   <= nxt_hit;
         end else begin
            y_q   <= 1'b0;
         end
         if (clr_cnt) begin
            cnt_q <= '0;
         end else if (en && nxt_hit && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign Y         = y_q;
   assign match_cnt = cnt_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector over four parameter sets
module tb_seq_detector;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic x = 1'b0;
   logic clr_cnt = 1'b0;

   logic [3:0]      y_o;
   logic [3:0][7:0] cnt_o;
   logic [3:0][4:0] st_o;
   logic [1:0]      c2_cnt;

   int n_vec = 0;
   int n_bad = 0;

   // Instance configurations: default, no-overlap, 2-bit counter, 5-bit pattern.
   int cfg_len [4] = '{4, 4, 4, 5};
   int cfg_pat [4] = '{11, 11, 11, 21};
   int cfg_ovl [4] = '{1, 0, 1, 1};
   int cfg_cw  [4] = '{8, 8, 2, 8};

   // Reference model: raw history of accepted bits, bits since last restart.
   int hist [4] = '{0, 0, 0, 0};
   int nb   [4] = '{0, 0, 0, 0};
   int mc   [4] = '{0, 0, 0, 0};
   int my   [4] = '{0, 0, 0, 0};

   typedef struct packed {
      logic [3:0]      y;
      logic [3:0][7:0] cnt;
      logic [3:0][4:0] st;
   } exp_t;

   exp_t exp_q[$];

   // Free-running clock.
   always #5 clk = ~clk;

   seq_detector u_def (
      .clk(clk), .rst(rst), .en(en), .X(x), .clr_cnt(clr_cnt),
      .Y(y_o[0]), .match_cnt(cnt_o[0]), .state_dbg(st_o[0])
   );

   seq_detector #(.OVERLAP(1'b0)) u_novl (
      .clk(clk), .rst(rst), .en(en), .X(x), .clr_cnt(clr_cnt),
      .Y(y_o[1]), .match_cnt(cnt_o[1]), .state_dbg(st_o[1])
   );

   seq_detector #(.CNT_W(2)) u_c2 (
      .clk(clk), .rst(rst), .en(en), .X(x), .clr_cnt(clr_cnt),
      .Y(y_o[2]), .match_cnt(c2_cnt), .state_dbg(st_o[2])
   );

   assign cnt_o[2] = {6'd0, c2_cnt};

   seq_detector #(.PAT_LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b1)) u_p5 (
      .clk(clk), .rst(rst), .en(en), .X(x), .clr_cnt(clr_cnt),
      .Y(y_o[3]), .match_cnt(cnt_o[3]), .state_dbg(st_o[3])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic xb, input logic c);
      exp_t ex;
      int   ms;
      int   len;
      int   pat;
      logic [1:0] ix;
      rst     = r;
      en      = e;
      x       = xb;
      clr_cnt = c;
      ex = '0;
      for (int i = 0; i < 4; i++) begin
         ix  = 2'(i);
         len = cfg_len[ix];
         pat = cfg_pat[ix];
         if (r) begin
            hist[ix] = 0;
            nb[ix]   = 0;
            mc[ix]   = 0;
            my[ix]   = 0;
         end else begin
            my[ix] = 0;
            if (e) begin
               hist[ix] = (hist[ix] << 1) | (xb ? 1 : 0);
               nb[ix]   = nb[ix] + 1;
               if (nb[ix] >= len && (hist[ix] & ((1 << len) - 1)) == pat) begin
                  my[ix] = 1;
                  if (mc[ix] < (1 << cfg_cw[ix]) - 1) mc[ix] = mc[ix] + 1;
                  if (cfg_ovl[ix] == 0) nb[ix] = 0;
               end
            end
            if (c) mc[ix] = 0;
         end
         ms = 0;
         for (int k = 1; k < len; k++) begin
            if (k <= nb[ix] && (hist[ix] & ((1 << k) - 1)) == (pat >> (len - k))) ms = k;
         end
         ex.y[ix]   = (my[ix] != 0);
         ex.cnt[ix] = 8'(mc[ix]);
         ex.st[ix]  = 5'(ms);
      end
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
         ix = 2'(i);
         chk($sformatf("y[%0d]", i),   {31'd0, y_o[ix]},   {31'd0, ex.y[ix]});
         chk($sformatf("cnt[%0d]", i), {24'd0, cnt_o[ix]}, {24'd0, ex.cnt[ix]});
         chk($sformatf("st[%0d]", i),  {27'd0, st_o[ix]},  {27'd0, ex.st[ix]});
      end
   endtask

   task automatic send(input int n, input logic [15:0] bits);
      logic [15:0] b;
      for (int k = n - 1; k >= 0; k--) begin
         b = bits >> k;
         step(1'b0, 1'b1, b[0], 1'b0);
      end
   endtask

   // Directed scenarios followed by a randomized tail, all against the model.
   initial begin
      #1;
      chk("powerup_y",   {31'd0, y_o[0]},   32'd0);
      chk("powerup_cnt", {24'd0, cnt_o[0]}, 32'd0);
      chk("powerup_st",  {27'd0, st_o[0]},  32'd0);

      // Basic stream, overlapping and non-overlapping
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("reset_st", {27'd0, st_o[0]}, 32'd0);
      send(7, 16'b1011011);
      chk("t1_cnt_overlap",  {24'd0, cnt_o[0]}, 32'd2);
      chk("t2_cnt_nooverlap", {24'd0, cnt_o[1]}, 32'd1);

      // Enable gaps hold the state
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("t3_hold_st", {27'd0, st_o[0]}, 32'd2);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t3_y", {31'd0, y_o[0]}, 32'd1);

      // Reset on the completing bit drops the match
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send(3, 16'b101);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t4_rst_y",  {31'd0, y_o[0]}, 32'd0);
      chk("t4_rst_st", {27'd0, st_o[0]}, 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_y",  {31'd0, y_o[0]}, 32'd0);
      chk("t4_st", {27'd0, st_o[0]}, 32'd1);

      // Counter saturation and clear coincident with a match
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send(16, 16'hBBBB);
      chk("t5_sat", {24'd0, cnt_o[2]}, 32'd3);
      send(3, 16'b101);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("t5_clr_y",   {31'd0, y_o[2]},   32'd1);
      chk("t5_clr_cnt", {24'd0, cnt_o[2]}, 32'd0);

      // Five-bit overlapping pattern
      step(1'b1, 1'b0, 1'b0, 1'b0);
      send(7, 16'b1010101);
      chk("t6_cnt", {24'd0, cnt_o[3]}, 32'd2);

      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (300) begin
         step($urandom_range(39) == 0, $urandom_range(3) != 0,
              1'($urandom_range(1)), $urandom_range(29) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
